// File: rtl/ft2232h_rx_frame_decoder_if.sv
// FT2232H synchronous 245 FIFO receive pins, seen from the FPGA.
// master = the FT2232H (or its model), slave = the frame decoder.
interface ft2232h_rx_frame_decoder_if;
    logic       rxf_i;   // RXF#, low = data available
    logic [7:0] data_i;  // FT data bus
    logic       oe_o;    // OE#, active low
    logic       rd_o;    // RD#, active low

    modport master (output rxf_i, output data_i, input oe_o, input rd_o);
    modport slave  (input rxf_i, input data_i, output oe_o, output rd_o);
endinterface

// File: rtl/ft2232h_rx_frame_decoder.sv
// FT2232H sync-FIFO reader plus frame parser:
//   PREAMBLE, channel address, DATA_BYTES payload, optional XOR checksum.
// Accepted payloads land in one of NUM_CHANNELS registers one cycle after
// the final frame byte, with a one-cycle update strobe.
module ft2232h_rx_frame_decoder #(
    parameter int         DATA_BYTES   = 1,
    parameter int         NUM_CHANNELS = 4,
    parameter logic [7:0] PREAMBLE     = 8'hAA,
    parameter bit         CHK_EN       = 1'b1,
    parameter int         TIMEOUT_CYC  = 1024,
    parameter int         ERR_CNT_W    = 8,
    localparam int        CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    ft2232h_rx_frame_decoder_if.slave             ft,
    output logic [NUM_CHANNELS*DATA_BYTES*8-1:0]  ch_data_o,
    output logic                                  upd_o,
    output logic [CH_W-1:0]                       upd_ch_o,
    output logic [ERR_CNT_W-1:0]                  err_cnt_o,
    output logic                                  busy_o
);
    localparam int W     = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(DATA_BYTES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam int CHD_W = NUM_CHANNELS * W;

    typedef enum logic [1:0] {BIDLE, BOE, BREAD} bus_e;
    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA, P_CHK} prs_e;

    bus_e               bstate_q, bstate_d;
    logic               oe_q, oe_d, rd_q, rd_d;
    prs_e               pstate_q, pstate_d;
    logic [CH_W-1:0]    addr_q, addr_d;
    logic [7:0]         chk_q, chk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       stage_q, stage_d;
    logic               commit_q, commit_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic [CHD_W-1:0]   ch_q, ch_d;
    logic               upd_q, upd_d;
    logic [CH_W-1:0]    upd_ch_q, upd_ch_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic               busy_q, busy_d;
    logic               err_ev;
    logic               acc;

    // A byte is taken only in BREAD with both strobes low and RXF# low.
    assign acc = (bstate_q == BREAD) && !oe_q && !rd_q && !ft.rxf_i;

    // Bus FSM: OE# leads RD# by one turnaround cycle; any RXF# high drops both.
    always_comb begin
        bstate_d = bstate_q;
        oe_d     = oe_q;
        rd_d     = rd_q;
        case (bstate_q)
            BIDLE: if (!ft.rxf_i) begin bstate_d = BOE; oe_d = 1'b0; end
            BOE: begin
                if (!ft.rxf_i) begin bstate_d = BREAD; rd_d = 1'b0; end
                else begin bstate_d = BIDLE; oe_d = 1'b1; end
            end
            BREAD: if (ft.rxf_i) begin bstate_d = BIDLE; oe_d = 1'b1; rd_d = 1'b1; end
            default: begin bstate_d = BIDLE; oe_d = 1'b1; rd_d = 1'b1; end
        endcase
    end

    // Parser FSM: steps on accepted bytes; idle timeout abandons an open frame.
    always_comb begin
        pstate_d = pstate_q;
        addr_d   = addr_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        commit_d = 1'b0;
        err_ev   = 1'b0;
        idle_d   = idle_q;
        if (acc) begin
            idle_d = '0;
            case (pstate_q)
                P_SYNC: if (ft.data_i == PREAMBLE) pstate_d = P_ADDR;
                P_ADDR: begin
                    if ({1'b0, ft.data_i} < 9'(NUM_CHANNELS)) begin
                        addr_d   = ft.data_i[CH_W-1:0];
                        chk_d    = ft.data_i;
                        cnt_d    = '0;
                        pstate_d = P_DATA;
                    end else begin
                        err_ev   = 1'b1;
                        pstate_d = P_SYNC;
                    end
                end
                P_DATA: begin
                    // first payload byte ends up in the MSBs
                    stage_d = (stage_q << 8) | W'(ft.data_i);
                    chk_d   = chk_q ^ ft.data_i;
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        if (CHK_EN) pstate_d = P_CHK;
                        else begin commit_d = 1'b1; pstate_d = P_SYNC; end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                P_CHK: begin
                    if (ft.data_i == chk_q) commit_d = 1'b1;
                    else err_ev = 1'b1;
                    pstate_d = P_SYNC;
                end
                default: pstate_d = P_SYNC;
            endcase
        end else if (pstate_q != P_SYNC) begin
            if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
                idle_d   = '0;
                err_ev   = 1'b1;
                pstate_d = P_SYNC;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    // Outputs: commit one cycle after the last byte; errors saturate, +1 max per cycle.
    always_comb begin
        ch_d     = ch_q;
        upd_d    = commit_q;
        upd_ch_d = upd_ch_q;
        err_d    = err_q;
        busy_d   = (pstate_d != P_SYNC);
        if (commit_q) begin
            upd_ch_d = addr_q;
            for (int k = 0; k < NUM_CHANNELS; k++)
                if (addr_q == CH_W'(k)) ch_d[k*W +: W] = stage_q;
        end
        if (err_ev && (err_q != '1)) err_d = err_q + ERR_CNT_W'(1);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bstate_q <= BIDLE;
            oe_q     <= 1'b1;
            rd_q     <= 1'b1;
            pstate_q <= P_SYNC;
            addr_q   <= '0;
            chk_q    <= '0;
            cnt_q    <= '0;
            stage_q  <= '0;
            commit_q <= 1'b0;
            idle_q   <= '0;
            ch_q     <= '0;
            upd_q    <= 1'b0;
            upd_ch_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            bstate_q <= bstate_d;
            oe_q     <= oe_d;
            rd_q     <= rd_d;
            pstate_q <= pstate_d;
            addr_q   <= addr_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            commit_q <= commit_d;
            idle_q   <= idle_d;
            ch_q     <= ch_d;
            upd_q    <= upd_d;
            upd_ch_q <= upd_ch_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign ft.oe_o   = oe_q;
    assign ft.rd_o   = rd_q;
    assign ch_data_o = ch_q;
    assign upd_o     = upd_q;
    assign upd_ch_o  = upd_ch_q;
    assign err_cnt_o = err_q;
    assign busy_o    = busy_q;
endmodule

// File: tb/tb_ft2232h_rx_frame_decoder.sv
// Directed bench: four decoder configurations share one FT byte-stream model;
// sel picks which one sees RXF# low and whose outputs are observed.
module tb_ft2232h_rx_frame_decoder;
    localparam int MAXC = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxf = 1'b1;
    logic [7:0] data = 8'h00;
    int         sel = 0;
    int         n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    ft2232h_rx_frame_decoder_if if_a (), if_b (), if_c (), if_d ();
    assign if_a.rxf_i = rxf | (sel != 0);
    assign if_b.rxf_i = rxf | (sel != 1);
    assign if_c.rxf_i = rxf | (sel != 2);
    assign if_d.rxf_i = rxf | (sel != 3);
    assign if_a.data_i = data;
    assign if_b.data_i = data;
    assign if_c.data_i = data;
    assign if_d.data_i = data;

    logic [31:0] ch_a, ch_b, ch_c, ch_d;
    logic        upd_a, upd_b, upd_c, upd_d;
    logic [1:0]  uch_a, uch_c, uch_d;
    logic [0:0]  uch_b;
    logic [7:0]  err_a, err_b, err_c;
    logic [1:0]  err_d;
    logic        busy_a, busy_b, busy_c, busy_d;

    ft2232h_rx_frame_decoder dut_a (
        .clk_i(clk), .rst_i(rst), .ft(if_a), .ch_data_o(ch_a), .upd_o(upd_a),
        .upd_ch_o(uch_a), .err_cnt_o(err_a), .busy_o(busy_a));
    ft2232h_rx_frame_decoder #(.DATA_BYTES(2), .NUM_CHANNELS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .ft(if_b), .ch_data_o(ch_b), .upd_o(upd_b),
        .upd_ch_o(uch_b), .err_cnt_o(err_b), .busy_o(busy_b));
    ft2232h_rx_frame_decoder #(.TIMEOUT_CYC(16)) dut_c (
        .clk_i(clk), .rst_i(rst), .ft(if_c), .ch_data_o(ch_c), .upd_o(upd_c),
        .upd_ch_o(uch_c), .err_cnt_o(err_c), .busy_o(busy_c));
    ft2232h_rx_frame_decoder #(.ERR_CNT_W(2)) dut_d (
        .clk_i(clk), .rst_i(rst), .ft(if_d), .ch_data_o(ch_d), .upd_o(upd_d),
        .upd_ch_o(uch_d), .err_cnt_o(err_d), .busy_o(busy_d));

    logic        oe_m, rd_m, upd_m, busy_m;
    logic [31:0] ch_m;
    logic [7:0]  uch_m, err_m;

    // observed-output mux
    always_comb begin
        oe_m = if_a.oe_o; rd_m = if_a.rd_o; upd_m = upd_a; busy_m = busy_a;
        ch_m = ch_a; uch_m = {6'd0, uch_a}; err_m = err_a;
        case (sel)
            1: begin oe_m = if_b.oe_o; rd_m = if_b.rd_o; upd_m = upd_b; busy_m = busy_b;
                     ch_m = ch_b; uch_m = {7'd0, uch_b}; err_m = err_b; end
            2: begin oe_m = if_c.oe_o; rd_m = if_c.rd_o; upd_m = upd_c; busy_m = busy_c;
                     ch_m = ch_c; uch_m = {6'd0, uch_c}; err_m = err_c; end
            3: begin oe_m = if_d.oe_o; rd_m = if_d.rd_o; upd_m = upd_d; busy_m = busy_d;
                     ch_m = ch_d; uch_m = {6'd0, uch_d}; err_m = {6'd0, err_d}; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] stim[$];
    int upd_cnt, upd_at, upd_first, last_acc, oe_falls, rd_falls, turn_bad;

    // FT model: presents stim bytes while RXF# low; a byte counts as taken when
    // RD# is already low going into the edge. Optional RXF# gap after gap_at.
    task automatic send(input int gap_at, input int gap_len, input int tail_n);
        int idx = 0, gap = 0, tail = 0, cyc = 0;
        logic prev_oe, prev_rd;
        prev_oe = oe_m; prev_rd = rd_m;
        upd_cnt = 0; upd_at = -1; upd_first = -1; last_acc = -1;
        oe_falls = 0; rd_falls = 0; turn_bad = 0;
        while (!(idx >= stim.size() && gap == 0 && tail >= tail_n) && cyc < MAXC) begin
            @(negedge clk);
            cyc++;
            if (upd_m) begin
                upd_cnt++; upd_at = cyc;
                if (upd_first < 0) upd_first = cyc;
            end
            if (!oe_m && prev_oe) oe_falls++;
            if (!rd_m && prev_rd) begin
                rd_falls++;
                if (prev_oe) turn_bad++;
            end
            prev_oe = oe_m; prev_rd = rd_m;
            if (idx < stim.size() && gap == 0) begin
                rxf = 1'b0; data = stim[idx];
                if (!rd_m) begin
                    if (idx == gap_at) gap = gap_len;
                    idx++; last_acc = cyc;
                end
            end else begin
                rxf = 1'b1;
                if (gap > 0) gap--;
                else tail++;
            end
        end
        chk("send_bound", 32'(cyc >= MAXC), 32'd0);
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("rst_oe", 32'(oe_m), 32'd1);
        chk("rst_rd", 32'(rd_m), 32'd1);
        chk("rst_ch", ch_m, 32'd0);
        chk("rst_upd", 32'(upd_m), 32'd0);
        chk("rst_err", 32'(err_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single good frame to channel 2
        sel = 0;
        stim = '{8'hAA, 8'h02, 8'h5A, 8'h58};
        send(-1, 0, 4);
        chk("t1_oe_falls", 32'(oe_falls), 32'd1);
        chk("t1_rd_falls", 32'(rd_falls), 32'd1);
        chk("t1_turnaround", 32'(turn_bad), 32'd0);
        chk("t1_ch", ch_m, 32'h005A_0000);
        chk("t1_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("t1_upd_ch", 32'(uch_m), 32'd2);
        chk("t1_latency", 32'(upd_at - last_acc), 32'd2);
        chk("t1_err", 32'(err_m), 32'd0);

        // 2: bad checksum, then bad address
        stim = '{8'hAA, 8'h02, 8'h5A, 8'h00, 8'hAA, 8'h07, 8'h11, 8'h16};
        send(-1, 0, 4);
        chk("t2_ch", ch_m, 32'h005A_0000);
        chk("t2_err", 32'(err_m), 32'd2);
        chk("t2_upd_cnt", 32'(upd_cnt), 32'd0);
        chk("t2_busy", 32'(busy_m), 32'd0);

        // 3: junk, then back-to-back frames, second one carries AA as payload
        stim = '{8'h00, 8'hFF, 8'hAA, 8'h01, 8'h33, 8'h32, 8'hAA, 8'h03, 8'hAA, 8'hA9};
        send(-1, 0, 4);
        chk("t3_ch", ch_m, 32'hAA5A_3300);
        chk("t3_upd_cnt", 32'(upd_cnt), 32'd2);
        chk("t3_upd_gap", 32'(upd_at - upd_first), 32'd4);
        chk("t3_upd_ch", 32'(uch_m), 32'd3);
        chk("t3_err", 32'(err_m), 32'd2);

        // 4: two-byte payload with a 3-cycle RXF# gap after 0x12
        sel = 1;
        stim = '{8'hAA, 8'h01, 8'h12, 8'h34, 8'h27};
        send(2, 3, 4);
        chk("t4_oe_falls", 32'(oe_falls), 32'd2);
        chk("t4_rd_falls", 32'(rd_falls), 32'd2);
        chk("t4_turnaround", 32'(turn_bad), 32'd0);
        chk("t4_ch", ch_m, 32'h1234_0000);
        chk("t4_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("t4_upd_ch", 32'(uch_m), 32'd1);
        chk("t4_err", 32'(err_m), 32'd0);

        // 5: timeout after 16 idle clocks, then a clean frame
        sel = 2;
        stim = '{8'hAA, 8'h00};
        send(-1, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 16) chk("t5_busy_before", 32'(busy_m), 32'd1);
            if (i == 17) begin
                chk("t5_busy_after", 32'(busy_m), 32'd0);
                chk("t5_err", 32'(err_m), 32'd1);
            end
            rxf = 1'b1;
        end
        stim = '{8'hAA, 8'h00, 8'h77, 8'h77};
        send(-1, 0, 4);
        chk("t5_ch", ch_m, 32'h0000_0077);
        chk("t5_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("t5_err_keep", 32'(err_m), 32'd1);

        // 6: saturation with a 2-bit counter, then mid-frame reset
        sel = 3;
        stim = {};
        for (int f = 0; f < 5; f++) stim = {stim, 8'hAA, 8'h01, 8'h33, 8'h00};
        send(-1, 0, 4);
        chk("t6_err_sat", 32'(err_m), 32'd3);
        chk("t6_upd_cnt", 32'(upd_cnt), 32'd0);
        stim = '{8'hAA, 8'h01};
        send(-1, 0, 0);
        @(negedge clk);
        chk("t6_busy_pre", 32'(busy_m), 32'd1);
        rst = 1'b0; rxf = 1'b1;
        @(negedge clk);
        chk("t6_rst_oe", 32'(oe_m), 32'd1);
        chk("t6_rst_rd", 32'(rd_m), 32'd1);
        chk("t6_rst_ch", ch_m, 32'd0);
        chk("t6_rst_upd", 32'(upd_m), 32'd0);
        chk("t6_rst_uch", 32'(uch_m), 32'd0);
        chk("t6_rst_err", 32'(err_m), 32'd0);
        chk("t6_rst_busy", 32'(busy_m), 32'd0);
        rst = 1'b1;
        stim = '{8'hAA, 8'h01, 8'h33, 8'h32};
        send(-1, 0, 4);
        chk("t6_ch", ch_m, 32'h0000_3300);
        chk("t6_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("t6_upd_ch", 32'(uch_m), 32'd1);
        chk("t6_err", 32'(err_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
